mac_pe_dbuf: RTL

//  Systolic-array processing element: weight-stationary multiply-accumulate with a double-buffered weight.
//  A shadow weight register loads through a vertical shift chain while the active weight keeps computing.
//  A swap token travels with the ifmap stream and commits the shadow weight, so reloads cost no stall cycles.

---
 rtl/mac_pe_dbuf.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mac_pe_dbuf.sv
// mac_pe_dbuf
//   Weight-stationary multiply-accumulate processing element for a systolic
//   array. The weight is double buffered: a shadow register fills through a
//   vertical shift chain while the active weight keeps computing. A swap token
//   that travels with the ifmap stream commits the shadow weight into the
//   active register, so a weight reload costs no stall cycles. Partial-sum
//   adds can saturate or wrap, overflow is recorded in a sticky flag, and the
//   partial sum bypasses the adder when no ifmap data is valid.
//
// Ports
//   clk, rstn                    clock (rising edge), asynchronous active-low reset
//   w_load_in, w_data_in         shadow-weight load strobe and data from the PE above
//   w_load_out, w_data_out       registered load strobe and shadow weight to the PE below
//   ifmap_valid_in, ifmap_data_in, w_swap_in
//                                ifmap operand and swap token from the west
//   ifmap_valid_out, ifmap_data_out, w_swap_out
//                                registered ifmap stream and qualified token to the east
//   psum_valid_in, psum_data_in  partial sum from the PE above
//   sat_en                       1: clamp on overflow, 0: wrap
//   ovf_clr                      synchronous clear of ovf_flag
//   psum_valid_out, psum_data_out registered partial sum to the PE below
//   ovf_flag                     sticky overflow indicator
module mac_pe_dbuf #(
  parameter int IFMAP_BITWIDTH = 16,
  parameter int W_BITWIDTH     = 8,
  parameter int OFMAP_BITWIDTH = 32,
  parameter bit SIGNED_MODE    = 1'b1
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      w_load_in,
  input  logic [W_BITWIDTH-1:0]     w_data_in,
  output logic                      w_load_out,
  output logic [W_BITWIDTH-1:0]     w_data_out,
  input  logic                      ifmap_valid_in,
  input  logic [IFMAP_BITWIDTH-1:0] ifmap_data_in,
  input  logic                      w_swap_in,
  output logic                      ifmap_valid_out,
  output logic [IFMAP_BITWIDTH-1:0] ifmap_data_out,
  output logic                      w_swap_out,
  input  logic                      psum_valid_in,
  input  logic [OFMAP_BITWIDTH-1:0] psum_data_in,
  input  logic                      sat_en,
  input  logic                      ovf_clr,
  output logic                      psum_valid_out,
  output logic [OFMAP_BITWIDTH-1:0] psum_data_out,
  output logic                      ovf_flag
);

  localparam int IFW  = IFMAP_BITWIDTH;
  localparam int WW   = W_BITWIDTH;
  localparam int OFW  = OFMAP_BITWIDTH;
  localparam int PW   = IFW + WW;
  localparam int EXTW = OFW + 1 - PW;

  // The product must fit in the partial sum, otherwise results silently truncate.
  if (OFW < PW) begin : g_width_check
    $error("mac_pe_dbuf: OFMAP_BITWIDTH must be >= IFMAP_BITWIDTH + W_BITWIDTH");
  end

  logic [WW-1:0]  shadow_w;
  logic [WW-1:0]  active_w;
  logic [IFW-1:0] ifmap_reg;

  logic [PW-1:0]  ifmap_ext;
  logic [PW-1:0]  weight_ext;
  logic [PW-1:0]  prod;
  logic [OFW:0]   prod_ext;
  logic [OFW:0]   psum_ext;
  logic [OFW:0]   sum;
  logic           overflow;
  logic [OFW-1:0] sat_value;
  logic [OFW-1:0] compute_result;

  assign w_data_out     = shadow_w;
  assign ifmap_data_out = ifmap_reg;

  // Weight chain: the shadow register captures on load and the strobe is
  // forwarded one cycle later so a column fills by shifting.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow_w   <= '0;
      w_load_out <= 1'b0;
    end else begin
      w_load_out <= w_load_in;
      if (w_load_in) begin
        shadow_w <= w_data_in;
      end
    end
  end

  // Stage 1: register the ifmap stream and commit the shadow weight on a
  // qualified swap token. Because active_w and ifmap_reg update on the same
  // edge, the ifmap carrying the token already multiplies with the new weight.
  // On a simultaneous load, active_w sees the shadow value from before the edge.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ifmap_reg       <= '0;
      ifmap_valid_out <= 1'b0;
      w_swap_out      <= 1'b0;
      active_w        <= '0;
    end else begin
      ifmap_valid_out <= ifmap_valid_in;
      w_swap_out      <= w_swap_in & ifmap_valid_in;
      if (ifmap_valid_in) begin
        ifmap_reg <= ifmap_data_in;
      end
      if (ifmap_valid_in && w_swap_in) begin
        active_w <= shadow_w;
      end
    end
  end

  // Operands are widened to the product width first so a plain multiply
  // yields the correct signed or unsigned product in its low bits.
  always_comb begin
    if (SIGNED_MODE) begin
      ifmap_ext  = {{WW{ifmap_reg[IFW-1]}}, ifmap_reg};
      weight_ext = {{IFW{active_w[WW-1]}}, active_w};
    end else begin
      ifmap_ext  = {{WW{1'b0}}, ifmap_reg};
      weight_ext = {{IFW{1'b0}}, active_w};
    end
    prod = ifmap_ext * weight_ext;
  end

  // The add is one bit wider than the partial sum; the two top bits differ
  // exactly when the true result does not fit in OFW signed bits, and the
  // top bit then gives the direction of the clamp.
  always_comb begin
    prod_ext       = {{EXTW{SIGNED_MODE & prod[PW-1]}}, prod};
    psum_ext       = {psum_data_in[OFW-1], psum_data_in};
    sum            = prod_ext + psum_ext;
    overflow       = sum[OFW] ^ sum[OFW-1];
    sat_value      = sum[OFW] ? {1'b1, {(OFW-1){1'b0}}} : {1'b0, {(OFW-1){1'b1}}};
    compute_result = (sat_en && overflow) ? sat_value : sum[OFW-1:0];
  end

  // Stage 2: accumulate when the registered ifmap is valid, otherwise pass the
  // incoming partial sum straight through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      psum_data_out  <= '0;
      psum_valid_out <= 1'b0;
    end else if (ifmap_valid_out) begin
      psum_data_out  <= compute_result;
      psum_valid_out <= ifmap_valid_out & psum_valid_in;
    end else begin
      psum_data_out  <= psum_data_in;
      psum_valid_out <= psum_valid_in;
    end
  end

  // Sticky overflow: a new overflow takes priority over a clear in the same cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf_flag <= 1'b0;
    end else if (ifmap_valid_out && overflow) begin
      ovf_flag <= 1'b1;
    end else if (ovf_clr) begin
      ovf_flag <= 1'b0;
    end
  end

endmodule
